// File: rtl/atmo_light_est.sv
// atmo_light_est: per-frame atmospheric light estimator with 1-cycle stream pass-through.
// Optional cross-frame IIR smoothing enabled by defining ATMO_IIR_EN.
module atmo_light_est #(
    parameter logic [7:0]  A_INIT    = 8'd255,
    parameter logic [7:0]  A_MIN     = 8'd128,
    parameter logic [7:0]  A_MAX     = 8'd250,
    parameter logic [21:0] MIN_PIX   = 22'd1024,
    parameter int          IIR_SHIFT = 2
) (
    input  logic       pixelclk,
    input  logic       reset,
    input  logic [7:0] dark_chanel_value,
    input  logic       i_de,
    input  logic       i_vsync,
    input  logic       i_hsync,
    output logic [7:0] o_dark,
    output logic       o_de,
    output logic       o_vsync,
    output logic       o_hsync,
    output logic [7:0] a_out,
    output logic       a_valid,
    output logic       frame_drop
);

    localparam logic [1:0] S_ACCUM  = 2'd0;
    localparam logic [1:0] S_EVAL   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam logic [21:0] PIX_SAT = 22'h3fffff;

    logic [1:0]  state_q, state_d;
    logic        vs_d_q, vs_d_d;
    logic [7:0]  cur_max_q, cur_max_d;
    logic [21:0] pix_cnt_q, pix_cnt_d;
    logic [9:0]  cand_q, cand_d;
    logic [7:0]  a_out_q, a_out_d;
    logic        a_valid_q, a_valid_d;
    logic        drop_pend_q, drop_pend_d;
    logic        frame_drop_q, frame_drop_d;
    logic [7:0]  o_dark_q, o_dark_d;
    logic        o_de_q, o_de_d;
    logic        o_vsync_q, o_vsync_d;
    logic        o_hsync_q, o_hsync_d;

    logic        frame_end;
    logic        clr;
    logic [9:0]  cand_w;
    logic [7:0]  base_max;
    logic [21:0] base_cnt;

    assign frame_end = i_vsync & ~vs_d_q;

`ifdef ATMO_IIR_EN
    localparam int IW = 8 + IIR_SHIFT + 1;
    localparam logic [IW-1:0] RND = IW'(1) << (IIR_SHIFT - 1);

    logic [IW-1:0] iir_sum;
    logic [IW-1:0] iir_shr;

    // Blend previous A with this frame's max, weight 1/2^k on the new frame, rounded.
    always_comb begin
        iir_sum = (IW'(a_out_q) << IIR_SHIFT) - IW'(a_out_q)
                + IW'(cur_max_q) + RND;
        iir_shr = iir_sum >> IIR_SHIFT;
        cand_w  = iir_shr[9:0];
    end
`else
    // Candidate is the raw per-frame maximum.
    always_comb begin
        cand_w = {2'b00, cur_max_q};
    end
`endif

    // Frame state machine, statistics accumulation and publish logic.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        a_out_d      = a_out_q;
        a_valid_d    = 1'b0;
        drop_pend_d  = 1'b0;
        frame_drop_d = drop_pend_q;
        clr          = 1'b0;

        unique case (state_q)
            S_ACCUM: begin
                if (frame_end) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                cand_d = cand_w;
                clr    = 1'b1;
                if (pix_cnt_q >= MIN_PIX) begin
                    state_d = S_UPDATE;
                end else begin
                    state_d     = S_ACCUM;
                    drop_pend_d = 1'b1;
                end
            end
            S_UPDATE: begin
                if (cand_q < {2'b00, A_MIN}) begin
                    a_out_d = A_MIN;
                end else if (cand_q > {2'b00, A_MAX}) begin
                    a_out_d = A_MAX;
                end else begin
                    a_out_d = cand_q[7:0];
                end
                a_valid_d = 1'b1;
                state_d   = S_ACCUM;
            end
            default: begin
                state_d = S_ACCUM;
            end
        endcase

        // Statistics are latched into cand_q before the clear, so pixels
        // seen during blanking-side states land in the next frame.
        base_max  = clr ? 8'd0 : cur_max_q;
        base_cnt  = clr ? 22'd0 : pix_cnt_q;
        cur_max_d = base_max;
        pix_cnt_d = base_cnt;
        if (i_de) begin
            if (dark_chanel_value > base_max) begin
                cur_max_d = dark_chanel_value;
            end
            if (base_cnt != PIX_SAT) begin
                pix_cnt_d = base_cnt + 22'd1;
            end
        end
    end

    // Stream pass-through and vsync edge history.
    always_comb begin
        vs_d_d    = i_vsync;
        o_dark_d  = dark_chanel_value;
        o_de_d    = i_de;
        o_vsync_d = i_vsync;
        o_hsync_d = i_hsync;
    end

    // State registers with synchronous reset.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state_q      <= S_ACCUM;
            vs_d_q       <= 1'b0;
            cur_max_q    <= 8'd0;
            pix_cnt_q    <= 22'd0;
            cand_q       <= 10'd0;
            a_out_q      <= A_INIT;
            a_valid_q    <= 1'b0;
            drop_pend_q  <= 1'b0;
            frame_drop_q <= 1'b0;
            o_dark_q     <= 8'd0;
            o_de_q       <= 1'b0;
            o_vsync_q    <= 1'b0;
            o_hsync_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_d_q       <= vs_d_d;
            cur_max_q    <= cur_max_d;
            pix_cnt_q    <= pix_cnt_d;
            cand_q       <= cand_d;
            a_out_q      <= a_out_d;
            a_valid_q    <= a_valid_d;
            drop_pend_q  <= drop_pend_d;
            frame_drop_q <= frame_drop_d;
            o_dark_q     <= o_dark_d;
            o_de_q       <= o_de_d;
            o_vsync_q    <= o_vsync_d;
            o_hsync_q    <= o_hsync_d;
        end
    end

    assign o_dark     = o_dark_q;
    assign o_de       = o_de_q;
    assign o_vsync    = o_vsync_q;
    assign o_hsync    = o_hsync_q;
    assign a_out      = a_out_q;
    assign a_valid    = a_valid_q;
    assign frame_drop = frame_drop_q;

endmodule
